// File: rtl/axis_upsizer.sv
// axis_upsizer: AXI4-Stream width up-converter.
// Packs RATIO narrow input beats little-endian into one wide output beat.
// A packet end (TLAST) flushes a partial word with unfilled lanes zeroed.
// One output register sits between the accumulator and the master port;
// the input is stalled only while that register holds an unaccepted word.
module axis_upsizer #(
  parameter int S_DATA_WIDTH = 64,
  parameter int RATIO        = 8
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [S_DATA_WIDTH-1:0]           S_AXIS_TDATA,
  input  logic [S_DATA_WIDTH/8-1:0]         S_AXIS_TKEEP,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [S_DATA_WIDTH*RATIO-1:0]     M_AXIS_TDATA,
  output logic [S_DATA_WIDTH*RATIO/8-1:0]   M_AXIS_TKEEP,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [31:0]                       word_count
);

  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8;
  localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8;
  localparam int LANE_W       = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Accumulator state
  logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [M_KEEP_WIDTH-1:0] acc_keep_q, acc_keep_d;
  logic [LANE_W-1:0]       lane_q, lane_d;

  // Output register state
  logic [M_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [M_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             word_count_q, word_count_d;

  // Handshake qualifiers
  logic                    s_ready;
  logic                    in_hs;
  logic                    out_hs;
  logic                    complete;

  // Accumulator merged with the current beat; lanes above it are forced to 0
  logic [M_DATA_WIDTH-1:0] merged_data;
  logic [M_KEEP_WIDTH-1:0] merged_keep;

  // The output register can take a new word when it is empty or being drained now.
  assign s_ready  = !areset && (!out_valid_q || M_AXIS_TREADY);
  assign in_hs    = S_AXIS_TVALID && s_ready;
  assign out_hs   = out_valid_q && M_AXIS_TREADY;
  assign complete = in_hs && ((lane_q == LAST_LANE) || S_AXIS_TLAST);

  // Build the word: earlier lanes from the accumulator, current lane from the input.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    merged_data = '0;
    merged_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) < lane_q) begin
        merged_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = acc_data_q[i*S_DATA_WIDTH +: S_DATA_WIDTH];
        merged_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = acc_keep_q[i*S_KEEP_WIDTH +: S_KEEP_WIDTH];
      end else if (LANE_W'(i) == lane_q) begin
        merged_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = S_AXIS_TDATA;
        merged_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = S_AXIS_TKEEP;
      end
    end
  end

  // Next-state for accumulator, output register and handshake counter.
  always_comb begin
    acc_data_d   = acc_data_q;
    acc_keep_d   = acc_keep_q;
    lane_d       = lane_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    word_count_d = word_count_q;

    // A drained word empties the register unless a completion refills it below.
    if (out_hs) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 32'd1;
    end

    if (in_hs) begin
      if (complete) begin
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = S_AXIS_TLAST;
        out_valid_d = 1'b1;
        acc_data_d  = '0;
        acc_keep_d  = '0;
        lane_d      = '0;
      end else begin
        acc_data_d  = merged_data;
        acc_keep_d  = merged_keep;
        lane_d      = lane_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any partial word and any pending output.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      // NOTE: the accumulator is a register bank, not a RAM, so it is reset
      // along with everything else; a mid-packet reset must not leak old lanes.
      acc_data_q   <= '0;
      acc_keep_q   <= '0;
      lane_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, so ordering inside this block cannot matter.
      acc_data_q   <= acc_data_d;
      acc_keep_q   <= acc_keep_d;
      lane_q       <= lane_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TKEEP  = out_keep_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer: a 64-bit x8 instance and a 32-bit x4 instance.
// Inputs change one time unit after the rising edge; outputs are sampled on the
// falling edge, where they are stable for the coming handshake edge.
module tb_axis_upsizer;

  logic aclk;
  logic areset;

  // 64-bit x 8 instance
  logic [63:0]  s_data;
  logic [7:0]   s_keep;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] m_data;
  logic [63:0]  m_keep;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic [31:0]  wcount;

  // 32-bit x 4 instance
  logic [31:0]  s32_data;
  logic [3:0]   s32_keep;
  logic         s32_valid;
  logic         s32_last;
  logic         s32_ready;
  logic [127:0] m32_data;
  logic [15:0]  m32_keep;
  logic         m32_valid;
  logic         m32_last;
  logic         m32_ready;
  logic [31:0]  wcount32;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } word_t;

  word_t q64[$];
  word_t q32[$];

  axis_upsizer #(.S_DATA_WIDTH(64), .RATIO(8)) u_dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s_data), .S_AXIS_TKEEP(s_keep), .S_AXIS_TVALID(s_valid),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TKEEP(m_keep), .M_AXIS_TVALID(m_valid),
    .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
    .word_count(wcount)
  );

  axis_upsizer #(.S_DATA_WIDTH(32), .RATIO(4)) u_dut32 (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s32_data), .S_AXIS_TKEEP(s32_keep), .S_AXIS_TVALID(s32_valid),
    .S_AXIS_TLAST(s32_last), .S_AXIS_TREADY(s32_ready),
    .M_AXIS_TDATA(m32_data), .M_AXIS_TKEEP(m32_keep), .M_AXIS_TVALID(m32_valid),
    .M_AXIS_TLAST(m32_last), .M_AXIS_TREADY(m32_ready),
    .word_count(wcount32)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Record every output handshake seen at the falling edge before it happens.
  always @(negedge aclk) begin
    if (!areset && m_valid && m_ready)
      q64.push_back('{d: m_data, k: m_keep, l: m_last});
    if (!areset && m32_valid && m32_ready)
      q32.push_back('{d: {384'd0, m32_data}, k: {48'd0, m32_keep}, l: m32_last});
  end

  // Consecutive byte values starting at 'first', 'n' bytes, rest zero.
  function automatic logic [511:0] bytes_from(input int first, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = 8'(first + i);
    return r;
  endfunction

  function automatic logic [63:0] ones(input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Beat b of the 64-bit stream carries bytes 8b .. 8b+7.
  function automatic logic [63:0] beat64(input int b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(8*b + i);
    return r;
  endfunction

  function automatic logic [31:0] beat32(input int b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(4*b + i);
    return r;
  endfunction

  // Offer one beat and hold it until accepted (bounded).
  task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic done;
    done = 1'b0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      done = s_ready;
      @(posedge aclk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!done) check("send64_timeout", 512'(done), 512'd1);
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic done;
    done = 1'b0;
    s32_data = d; s32_keep = k; s32_last = l; s32_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      done = s32_ready;
      @(posedge aclk); #1;
    end
    s32_valid = 1'b0; s32_last = 1'b0;
    if (!done) check("send32_timeout", 512'(done), 512'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pop64(input string tag, input logic [511:0] d, input logic [63:0] k, input logic l);
    word_t w;
    if (q64.size() == 0) begin
      check({tag, "_present"}, 512'd0, 512'd1);
    end else begin
      w = q64.pop_front();
      check({tag, "_data"}, w.d, d);
      check({tag, "_keep"}, 512'(w.k), 512'(k));
      check({tag, "_last"}, 512'(w.l), 512'(l));
    end
  endtask

  logic [511:0] held_data;

  initial begin
    areset = 1'b1;
    s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    s32_data = '0; s32_keep = '0; s32_valid = 1'b0; s32_last = 1'b0; m32_ready = 1'b1;

    // Reset state
    @(negedge aclk);
    check("rst_valid", 512'(m_valid), 512'd0);
    check("rst_last", 512'(m_last), 512'd0);
    check("rst_data", m_data, 512'd0);
    check("rst_keep", 512'(m_keep), 512'd0);
    check("rst_s_ready", 512'(s_ready), 512'd0);
    check("rst_wcount", 512'(wcount), 512'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    idle(1);

    // T1: one full 8-beat packet, valid appears right after beat 8
    for (int b = 0; b < 7; b++) send64(beat64(b), 8'hFF, 1'b0);
    check("t1_not_valid_before_last", 512'(m_valid), 512'd0);
    send64(beat64(7), 8'hFF, 1'b1);
    check("t1_valid_after_last", 512'(m_valid), 512'd1);
    idle(3);
    check("t1_count", 512'(q64.size()), 512'd1);
    pop64("t1_w", bytes_from(0, 64), ones(64), 1'b1);
    check("t1_wcount", 512'(wcount), 512'd1);
    check("t1_valid_cleared", 512'(m_valid), 512'd0);

    // T2: 12 beats with an input gap; full word then half word flushed by TLAST
    for (int b = 0; b < 12; b++) begin
      send64(beat64(b), 8'hFF, b == 11);
      if (b == 5) idle(2);
    end
    idle(3);
    check("t2_count", 512'(q64.size()), 512'd2);
    pop64("t2_w1", bytes_from(0, 64), ones(64), 1'b0);
    pop64("t2_w2", bytes_from(8'h40, 32), 64'h0000_0000_FFFF_FFFF, 1'b1);
    check("t2_wcount", 512'(wcount), 512'd3);

    // T3: backpressure while 16 beats are offered
    m_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 16; b++) send64(beat64(b), 8'hFF, b == 15);
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge aclk);
          seen = m_valid;
        end
        check("t3_word1_valid", 512'(seen), 512'd1);
        check("t3_s_ready_stalled", 512'(s_ready), 512'd0);
        held_data = m_data;
        repeat (5) @(negedge aclk);
        check("t3_data_stable", m_data, held_data);
        check("t3_still_stalled", 512'(s_ready), 512'd0);
        @(posedge aclk); #1;
        m_ready = 1'b1;
      end
    join
    idle(3);
    check("t3_count", 512'(q64.size()), 512'd2);
    pop64("t3_w1", bytes_from(0, 64), ones(64), 1'b0);
    pop64("t3_w2", bytes_from(8'h40, 64), ones(64), 1'b1);
    check("t3_wcount", 512'(wcount), 512'd5);

    // T4: single-beat packet with partial keep
    send64(64'h1122_3344_5566_7788, 8'h0F, 1'b1);
    idle(3);
    check("t4_count", 512'(q64.size()), 512'd1);
    pop64("t4_w", 512'h1122_3344_5566_7788, 64'h0000_0000_0000_000F, 1'b1);
    check("t4_wcount", 512'(wcount), 512'd6);

    // T5: 32-bit x 4 instance, one full word
    for (int b = 0; b < 4; b++) send32(beat32(b), 4'hF, b == 3);
    idle(3);
    check("t5_count", 512'(q32.size()), 512'd1);
    if (q32.size() > 0) begin
      word_t w;
      w = q32.pop_front();
      check("t5_data", w.d, bytes_from(0, 16));
      check("t5_keep", 512'(w.k), 512'h0000_0000_0000_FFFF);
      check("t5_last", 512'(w.l), 512'd1);
    end
    check("t5_wcount", 512'(wcount32), 512'd1);

    // T6: reset after 3 of 8 beats, then a fresh packet lands from lane 0
    for (int b = 0; b < 3; b++) send64(beat64(b), 8'hFF, 1'b0);
    areset = 1'b1;
    #1;
    check("t6_rst_valid", 512'(m_valid), 512'd0);
    check("t6_rst_data", m_data, 512'd0);
    check("t6_rst_keep", 512'(m_keep), 512'd0);
    check("t6_rst_last", 512'(m_last), 512'd0);
    check("t6_rst_s_ready", 512'(s_ready), 512'd0);
    check("t6_rst_wcount", 512'(wcount), 512'd0);
    idle(2);
    areset = 1'b0;
    q64.delete();
    idle(1);
    for (int b = 16; b < 24; b++) send64(beat64(b), 8'hFF, b == 23);
    idle(3);
    check("t6_count", 512'(q64.size()), 512'd1);
    pop64("t6_w", bytes_from(8'h80, 64), ones(64), 1'b1);
    check("t6_wcount", 512'(wcount), 512'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
